hack_cpu: RTL and testbench

Single-cycle Hack CPU core that sits directly upstream of the 16-bit `ALU`. It fetches nothing itself: it decodes the instruction word presented by instruction ROM, drives the ALU's operands and six control bits, and holds the A, D and PC state. It consumes the ALU's `out`/`zr`/`ng` results for register writeback, data-memory writes and jump resolution.

---
 rtl/hack_pkg.sv | 28 ++
 rtl/alu.sv | 28 ++
 rtl/hack_pc.sv | 20 ++
 rtl/mux2_1_16bit.sv | 9 +
 rtl/hack_cpu.sv | 81 ++++++++
 tb/tb_hack_cpu.sv | 170 +++++++++++++++++
 6 files changed

// File: rtl/hack_pkg.sv
// Shared Hack CPU definitions: word width and instruction field positions.
package hack_pkg;
    localparam int WORD_W     = 16;
    localparam int INSTR_TYPE = 15;
    localparam int A_BIT      = 12;
    localparam int COMP_HI    = 11;
    localparam int COMP_LO    = 6;
    localparam int DEST_HI    = 5;
    localparam int DEST_LO    = 3;
    localparam int JMP_HI     = 2;
    localparam int JMP_LO     = 0;

    typedef struct packed {
        logic d_a;
        logic d_d;
        logic d_m;
    } dest_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } jmp_t;

    function automatic logic jump_taken(jmp_t j, logic zr, logic ng);
        return (j.lt & ng) | (j.eq & zr) | (j.gt & ~ng & ~zr);
    endfunction
endpackage

// File: rtl/alu.sv
// Hack 16-bit ALU: zero/negate each operand, add or AND, optionally negate result.
module ALU (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);
    logic [15:0] xz, xn, yz, yn, r;

    always_comb begin
        xz  = zx ? 16'h0000 : x;
        xn  = nx ? ~xz : xz;
        yz  = zy ? 16'h0000 : y;
        yn  = ny ? ~yz : yz;
        r   = f ? (xn + yn) : (xn & yn);
        out = no ? ~r : r;
    end

    assign zr = (out == 16'h0000);
    assign ng = out[15];
endmodule

// File: rtl/hack_pc.sv
// Program counter: synchronous reset, then load / increment when enabled, else hold.
module hack_pc
    import hack_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] pc
);
    always_ff @(posedge clk) begin
        if (reset)
            pc <= RESET_PC;
        else if (en)
            pc <= load ? din : pc + {{(WORD_W-1){1'b0}}, 1'b1};
    end
endmodule

// File: rtl/mux2_1_16bit.sv
// 16-bit 2:1 multiplexer; sel=1 picks b.
module mux2_1_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sel,
    output logic [15:0] out
);
    assign out = sel ? b : a;
endmodule

// File: rtl/hack_cpu.sv
// Single-cycle Hack CPU core: decodes the ROM word, drives the ALU, holds A, D and PC.
module hack_cpu
    import hack_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instruction,
    input  logic             instr_valid,
    input  logic [WIDTH-1:0] inM,
    output logic [WIDTH-1:0] outM,
    output logic             writeM,
    output logic [WIDTH-1:0] addressM,
    output logic [WIDTH-1:0] pc
);
    logic [WIDTH-1:0] a_reg, d_reg, y, alu_out;
    logic             zr, ng, is_c, jump, load_a;
    logic [5:0]       comp;
    dest_t            dest;
    jmp_t             jmp;
    logic             unused_bits;

    assign is_c        = instruction[INSTR_TYPE];
    assign comp        = instruction[COMP_HI:COMP_LO];
    assign dest        = instruction[DEST_HI:DEST_LO];
    assign jmp         = instruction[JMP_HI:JMP_LO];
    assign unused_bits = ^instruction[14:13];

    mux2_1_16bit u_ymux (
        .a   (a_reg),
        .b   (inM),
        .sel (instruction[A_BIT]),
        .out (y)
    );

    ALU u_alu (
        .x   (d_reg),
        .y   (y),
        .zx  (comp[5]),
        .nx  (comp[4]),
        .zy  (comp[3]),
        .ny  (comp[2]),
        .f   (comp[1]),
        .no  (comp[0]),
        .out (alu_out),
        .zr  (zr),
        .ng  (ng)
    );

    // A-instructions always load A; C-instructions only with dA.
    assign load_a = ~is_c | dest.d_a;
    assign jump   = is_c & jump_taken(jmp, zr, ng);

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg <= '0;
            d_reg <= '0;
        end else if (instr_valid) begin
            if (load_a)
                a_reg <= is_c ? alu_out : instruction;
            if (is_c && dest.d_d)
                d_reg <= alu_out;
        end
    end

    // Jump target is the pre-update A, so a simultaneous dA lands a cycle later.
    hack_pc #(.RESET_PC(RESET_PC)) u_pc (
        .clk   (clk),
        .reset (reset),
        .en    (instr_valid),
        .load  (jump),
        .din   (a_reg),
        .pc    (pc)
    );

    assign outM     = alu_out;
    assign writeM   = is_c & dest.d_m & instr_valid & ~reset;
    assign addressM = a_reg;
endmodule

// File: tb/tb_hack_cpu.sv
// Self-checking bench for hack_cpu: directed vector table, hand sequences, random vs model.
module tb_hack_cpu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instruction = 16'h0;
    logic        instr_valid = 1'b0;
    logic [15:0] inM = 16'h0;
    logic [15:0] outM, addressM, pc;
    logic        writeM;

    int checks = 0;
    int errors = 0;

    hack_cpu dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .inM         (inM),
        .outM        (outM),
        .writeM      (writeM),
        .addressM    (addressM),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic        valid;
        logic        rst;
        logic        chk_out;
        logic        wm;
        logic [15:0] outm;
        logic [15:0] pc;
        logic [15:0] addr;
    } vec_t;

    vec_t tbl[$];

    // Reference state
    logic [15:0] m_a, m_d, m_pc;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called one time unit after a rising edge: drive, check combinational, clock, check state.
    task automatic step(input string tag, input vec_t v, input logic [15:0] inm);
        instruction = v.instr;
        instr_valid = v.valid;
        reset       = v.rst;
        inM         = inm;
        #2;
        chk({tag, ".writeM"}, {15'h0, writeM}, {15'h0, v.wm});
        if (v.chk_out) chk({tag, ".outM"}, outM, v.outm);
        @(posedge clk);
        #1;
        chk({tag, ".pc"}, pc, v.pc);
        chk({tag, ".addressM"}, addressM, v.addr);
    endtask

    function automatic logic [15:0] alu_ref(logic [15:0] x, logic [15:0] y, logic [5:0] c);
        logic [15:0] xx, yy, r;
        xx = c[5] ? 16'd0 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'd0 : y;
        if (c[2]) yy = ~yy;
        r = c[1] ? 16'(xx + yy) : (xx & yy);
        return c[0] ? ~r : r;
    endfunction

    // Computes expectations for one instruction and advances the model state.
    task automatic model_step(input logic [15:0] ins, input logic v, input logic r,
                              input logic [15:0] inm, output vec_t e);
        logic [15:0] res, npc;
        logic        jmp, isc;
        isc = ins[15];
        res = alu_ref(m_d, ins[12] ? inm : m_a, ins[11:6]);
        jmp = isc && ((ins[2] && res[15]) || (ins[1] && res == 16'd0) ||
                      (ins[0] && !res[15] && res != 16'd0));
        e.instr = ins; e.valid = v; e.rst = r;
        e.wm = isc && ins[3] && v && !r;
        e.chk_out = e.wm;
        e.outm = res;
        if (r) begin
            m_pc = 16'h0000; m_a = 16'd0; m_d = 16'd0;
        end else if (v) begin
            npc = jmp ? m_a : m_pc + 16'd1;
            if (!isc) m_a = ins;
            else begin
                if (ins[4]) m_d = res;
                if (ins[5]) m_a = res;
            end
            m_pc = npc;
        end
        e.pc = m_pc;
        e.addr = m_a;
    endtask

    initial begin
        vec_t e;
        // instr, valid, rst, chk_out, wm, outm, pc, addr
        tbl.push_back('{16'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{16'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{16'hE308, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 16'h0000});
        tbl.push_back('{16'h0015, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'h0015});
        tbl.push_back('{16'hEC10, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0015, 16'h0003, 16'h0015});
        tbl.push_back('{16'h0064, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h0064});
        tbl.push_back('{16'hE7C8, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0016, 16'h0005, 16'h0064});
        tbl.push_back('{16'h0007, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0006, 16'h0007});
        tbl.push_back('{16'hEA87, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0007, 16'h0007});
        tbl.push_back('{16'hEA90, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0008, 16'h0007});
        tbl.push_back('{16'hE301, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0009, 16'h0007});
        tbl.push_back('{16'hEE90, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h000A, 16'h0007});
        tbl.push_back('{16'h0030, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h000B, 16'h0030});
        tbl.push_back('{16'hE304, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0030, 16'h0030});
        tbl.push_back('{16'hE308, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0031, 16'h0030});
        tbl.push_back('{16'h0040, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0032, 16'h0040});
        tbl.push_back('{16'hE327, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0040, 16'hFFFF});
        tbl.push_back('{16'h0050, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0041, 16'h0050});
        tbl.push_back('{16'hE7E8, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0042, 16'h0000});
        tbl.push_back('{16'hE7C8, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{16'hE308, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 16'h0000});

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i], 16'($urandom));

        // Stall: D=D-1 held off for three cycles, then executed once.
        for (int i = 0; i < 3; i++)
            step("stall", '{16'hE390, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0000}, 16'($urandom));
        step("stall_d", '{16'hE308, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0001, 16'h0000}, 16'($urandom));
        step("dec",     '{16'hE390, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0002, 16'h0000}, 16'($urandom));
        step("dec_d",   '{16'hE308, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0003, 16'h0000}, 16'($urandom));

        // PC wrap: A=-1, jump there, then fall through past 16'hFFFF.
        step("wrap_a",  '{16'hEEA0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0004, 16'hFFFF}, 16'($urandom));
        step("wrap_j",  '{16'hEA87, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'hFFFF}, 16'($urandom));
        step("wrap_0",  '{16'hE300, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF}, 16'($urandom));
        step("wrap_1",  '{16'hE300, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF}, 16'($urandom));

        // Random program against the reference model, starting from reset.
        m_a = 16'hx; m_d = 16'hx; m_pc = 16'hx;
        begin
            logic [15:0] ins, inm;
            logic        v, r;
            ins = 16'($urandom); inm = 16'($urandom);
            model_step(ins, 1'b1, 1'b1, inm, e);
            e.chk_out = 1'b0;
            step("rnd_rst", e, inm);
            for (int i = 0; i < 400; i++) begin
                ins = 16'($urandom);
                inm = 16'($urandom);
                v   = ($urandom_range(9) != 0);
                r   = ($urandom_range(39) == 0);
                model_step(ins, v, r, inm, e);
                step($sformatf("rnd%0d", i), e, inm);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
